// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU run controller: FSM states, run modes and
// the stop-cause codes reported on done_cause.
package cpu_ctrl_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_RST_HOLD  = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_RUN       = 3'd2;
  localparam logic [2:0] ST_STEP_WAIT = 3'd3;
  localparam logic [2:0] ST_STEP_EXEC = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  // Run modes; code 3 is reserved and behaves like MODE_FREE
  localparam logic [1:0] MODE_FREE    = 2'd0;
  localparam logic [1:0] MODE_BOUNDED = 2'd1;
  localparam logic [1:0] MODE_STEP    = 2'd2;

  // Reasons a run ended
  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_HALT  = 2'd1;
  localparam logic [1:0] CAUSE_LIMIT = 2'd2;
  localparam logic [1:0] CAUSE_STOP  = 2'd3;

  // States in which a run is in progress
  function automatic logic is_busy(input logic [2:0] st);
    return (st == ST_RUN) || (st == ST_STEP_WAIT) || (st == ST_STEP_EXEC);
  endfunction

  // States in which the CPU clock is enabled
  function automatic logic is_enabled(input logic [2:0] st);
    return (st == ST_RUN) || (st == ST_STEP_EXEC);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_rst_sync.sv
// Two-flop reset synchroniser: assertion follows reset_n immediately,
// release reaches rst_sync_n on the second rising edge after reset_n rises.
module rst_sync (
  input  logic clk,
  input  logic reset_n,
  output logic rst_sync_n
);

  logic meta_q;
  logic sync_q;

  // Shift a constant 1 through two flops; both clear asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= 1'b1;
      sync_q <= meta_q;
    end
  end

  assign rst_sync_n = sync_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle CPU: stretches reset, gates the CPU
// clock enable in free-run, bounded-run and single-step modes, counts enabled
// cycles and reports why a run stopped.
//
// Control inputs are single-cycle pulses sampled on the rising edge; there is
// no back-pressure. start is only accepted in IDLE/DONE, step only in
// STEP_WAIT, and halt_req only while cpu_clk_en is high. Every output is a
// flop decoded from the next state, so no input reaches an output
// combinationally.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] run_limit,
  input  logic             step,
  input  logic             stop,
  input  logic             halt_req,
  output logic             cpu_rst,
  output logic             cpu_clk_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic             done,
  output logic [1:0]       done_cause,
  output logic             busy
);

  localparam int HOLD_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

  logic rst_n;

  rst_sync u_rst_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .rst_sync_n (rst_n)
  );

  logic [2:0]        state_q,   state_d;
  logic [HOLD_W-1:0] hold_q,    hold_d;
  logic [1:0]        mode_q,    mode_d;
  logic [CNT_W-1:0]  limit_q,   limit_d;
  logic [CNT_W-1:0]  count_q,   count_d;
  logic [1:0]        cause_q,   cause_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              clk_en_q,  clk_en_d;
  logic              done_q,    done_d;
  logic              busy_q,    busy_d;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    mode_d  = mode_q;
    limit_d = limit_q;
    cause_d = cause_q;

    // The counter follows the registered enable, so the cycle that ends at
    // this edge is counted even when the FSM leaves RUN on the same edge.
    count_d = count_q;
    if (clk_en_q && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end

    case (state_q)
      ST_RST_HOLD: begin
        // The FSM is only out of reset once the synchroniser has released
        if (hold_q == HOLD_LAST) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      ST_IDLE, ST_DONE: begin
        if (start) begin
          mode_d  = mode;
          limit_d = run_limit;
          count_d = '0;
          cause_d = CAUSE_NONE;
          case (mode)
            MODE_BOUNDED: begin
              if (run_limit == '0) begin
                state_d = ST_DONE;
                cause_d = CAUSE_LIMIT;
              end else begin
                state_d = ST_RUN;
              end
            end
            MODE_STEP: state_d = ST_STEP_WAIT;
            default:   state_d = ST_RUN;
          endcase
        end
      end

      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_DONE;
          cause_d = CAUSE_HALT;
        end else if (stop) begin
          state_d = ST_DONE;
          cause_d = CAUSE_STOP;
        end else if ((mode_q == MODE_BOUNDED) && (count_d == limit_q)) begin
          state_d = ST_DONE;
          cause_d = CAUSE_LIMIT;
        end
      end

      ST_STEP_WAIT: begin
        // stop takes precedence over a coincident step
        if (stop) begin
          state_d = ST_DONE;
          cause_d = CAUSE_STOP;
        end else if (step) begin
          state_d = ST_STEP_EXEC;
        end
      end

      ST_STEP_EXEC: begin
        if (halt_req) begin
          state_d = ST_DONE;
          cause_d = CAUSE_HALT;
        end else if (stop) begin
          state_d = ST_DONE;
          cause_d = CAUSE_STOP;
        end else begin
          state_d = ST_STEP_WAIT;
        end
      end

      default: state_d = ST_RST_HOLD;
    endcase

    cpu_rst_d = (state_d == ST_RST_HOLD);
    clk_en_d  = is_enabled(state_d);
    done_d    = (state_d == ST_DONE);
    busy_d    = is_busy(state_d);
  end

  // State, counters and output flops; reset asserts as soon as reset_n drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RST_HOLD;
      hold_q    <= '0;
      mode_q    <= MODE_FREE;
      limit_q   <= '0;
      count_q   <= '0;
      cause_q   <= CAUSE_NONE;
      cpu_rst_q <= 1'b1;
      clk_en_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      mode_q    <= mode_d;
      limit_q   <= limit_d;
      count_q   <= count_d;
      cause_q   <= cause_d;
      cpu_rst_q <= cpu_rst_d;
      clk_en_q  <= clk_en_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign cpu_rst     = cpu_rst_q;
  assign cpu_clk_en  = clk_en_q;
  assign cycle_count = count_q;
  assign done        = done_q;
  assign done_cause  = cause_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: a default instance (CNT_W=32) and a narrow
// instance (CNT_W=4) share all stimulus; the narrow one is checked for
// counter saturation.
module tb_cpu_run_ctrl;
  import cpu_ctrl_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         start;
  logic [1:0]   mode;
  logic [W-1:0] run_limit;
  logic         step;
  logic         stop;
  logic         halt_req;

  logic         cpu_rst, cpu_clk_en, done, busy;
  logic [W-1:0] cycle_count;
  logic [1:0]   done_cause;

  logic         s_cpu_rst, s_cpu_clk_en, s_done, s_busy;
  logic [3:0]   s_cycle_count;
  logic [1:0]   s_done_cause;
  logic [3:0]   run_limit_s;
  assign run_limit_s = run_limit[3:0];

  cpu_run_ctrl #(.RST_CYCLES(2), .CNT_W(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .run_limit(run_limit), .step(step), .stop(stop), .halt_req(halt_req),
    .cpu_rst(cpu_rst), .cpu_clk_en(cpu_clk_en), .cycle_count(cycle_count),
    .done(done), .done_cause(done_cause), .busy(busy)
  );

  cpu_run_ctrl #(.RST_CYCLES(2), .CNT_W(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .run_limit(run_limit_s), .step(step), .stop(stop), .halt_req(halt_req),
    .cpu_rst(s_cpu_rst), .cpu_clk_en(s_cpu_clk_en), .cycle_count(s_cycle_count),
    .done(s_done), .done_cause(s_done_cause), .busy(s_busy)
  );

  // ---------------- scoreboard ----------------
  // Entries are {cause, count}
  logic [W+1:0] exp_q[$];
  logic [W+1:0] exp_v;
  int total = 0;
  int bad   = 0;

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic [1:0] m, input logic [W-1:0] lim);
    @(negedge clk);
    start     = 1'b1;
    mode      = m;
    run_limit = lim;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Watch the run from the negedge after the start edge. halt_req/stop are
  // raised during the cycle that ends at the chosen enabled edge (0 = never).
  task automatic run_until_done(input int max_cyc, input int halt_at, input int stop_at,
                                output int cyc, output int en, output bit timeout);
    en = 0;
    cyc = 0;
    timeout = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      if (done) begin
        timeout = 1'b0;
        break;
      end
      if (cpu_clk_en) en++;
      halt_req = cpu_clk_en && (en == halt_at);
      stop     = cpu_clk_en && (en == stop_at);
      cyc++;
      @(negedge clk);
    end
    halt_req = 1'b0;
    stop     = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic exp_rst;
    reset_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (cpu_rst !== 1'b1 || cpu_clk_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          done_cause !== 2'd0 || cycle_count !== '0) begin
        bad++;
        $display("FAIL reset_hold: rst=%b en=%b busy=%b done=%b cause=%0d cnt=%0d, want rst=1 others 0",
                 cpu_rst, cpu_clk_en, busy, done, done_cause, cycle_count);
      end
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      exp_rst = (k < 4);
      total++;
      if (cpu_rst !== exp_rst || cpu_clk_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          done_cause !== 2'd0 || cycle_count !== '0) begin
        bad++;
        $display("FAIL reset_release edge %0d: rst=%b en=%b busy=%b done=%b, want rst=%b others 0",
                 k, cpu_rst, cpu_clk_en, busy, done, exp_rst);
      end
    end
  endtask

  task automatic test_bounded();
    int cyc, en;
    bit to;
    exp_q.push_back({CAUSE_LIMIT, 32'd10});
    start_run(MODE_BOUNDED, 32'd10);
    run_until_done(100, 0, 0, cyc, en, to);
    exp_v = exp_q.pop_front();
    total++;
    if (to || {done_cause, cycle_count} !== exp_v) begin
      bad++;
      $display("FAIL bounded10: timeout=%b cause=%0d cnt=%0d, want cause=%0d cnt=%0d",
               to, done_cause, cycle_count, exp_v[W+1:W], exp_v[W-1:0]);
    end
    total++;
    if (en !== 10 || cpu_clk_en !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bounded10_enables: en_edges=%0d en=%b busy=%b, want 10 0 0", en, cpu_clk_en, busy);
    end

    exp_q.push_back({CAUSE_LIMIT, 32'd0});
    start_run(MODE_BOUNDED, 32'd0);
    run_until_done(10, 0, 0, cyc, en, to);
    exp_v = exp_q.pop_front();
    total++;
    if (to || cyc !== 0 || en !== 0 || {done_cause, cycle_count} !== exp_v) begin
      bad++;
      $display("FAIL bounded0: timeout=%b wait=%0d en_edges=%0d cause=%0d cnt=%0d, want wait=0 en=0 cause=2 cnt=0",
               to, cyc, en, done_cause, cycle_count);
    end
  endtask

  task automatic test_halt();
    int cyc, en;
    bit to;
    exp_q.push_back({CAUSE_HALT, 32'd7});
    start_run(MODE_FREE, 32'd0);
    total++;
    if (busy !== 1'b1 || cpu_clk_en !== 1'b1 || cycle_count !== '0 || done !== 1'b0) begin
      bad++;
      $display("FAIL free_start: busy=%b en=%b cnt=%0d done=%b, want 1 1 0 0",
               busy, cpu_clk_en, cycle_count, done);
    end
    run_until_done(100, 7, 0, cyc, en, to);
    exp_v = exp_q.pop_front();
    total++;
    if (to || en !== 7 || {done_cause, cycle_count} !== exp_v) begin
      bad++;
      $display("FAIL free_halt7: timeout=%b en_edges=%0d cause=%0d cnt=%0d, want en=7 cause=1 cnt=7",
               to, en, done_cause, cycle_count);
    end

    exp_q.push_back({CAUSE_HALT, 32'd7});
    start_run(MODE_BOUNDED, 32'd7);
    run_until_done(100, 7, 0, cyc, en, to);
    exp_v = exp_q.pop_front();
    total++;
    if (to || {done_cause, cycle_count} !== exp_v) begin
      bad++;
      $display("FAIL halt_beats_limit: timeout=%b cause=%0d cnt=%0d, want cause=%0d cnt=%0d",
               to, done_cause, cycle_count, exp_v[W+1:W], exp_v[W-1:0]);
    end
  endtask

  task automatic test_single_step();
    int en_total;
    start_run(MODE_STEP, 32'd0);
    total++;
    if (busy !== 1'b1 || cpu_clk_en !== 1'b0 || cycle_count !== '0) begin
      bad++;
      $display("FAIL step_wait_entry: busy=%b en=%b cnt=%0d, want 1 0 0", busy, cpu_clk_en, cycle_count);
    end
    en_total = 0;
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      total++;
      if (cpu_clk_en !== 1'b1) begin
        bad++;
        $display("FAIL step_enable pulse %0d: en=%b, want 1", p, cpu_clk_en);
      end
      for (int j = 0; j < 4; j++) begin
        if (cpu_clk_en) en_total++;
        if (j < 3) @(negedge clk);
      end
    end
    total++;
    if (en_total !== 3 || cycle_count !== 32'd3 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL step_three: en_edges=%0d cnt=%0d busy=%b done=%b, want 3 3 1 0",
               en_total, cycle_count, busy, done);
    end
    exp_q.push_back({CAUSE_STOP, 32'd3});
    @(negedge clk);
    stop = 1'b1;
    step = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    step = 1'b0;
    exp_v = exp_q.pop_front();
    total++;
    if (done !== 1'b1 || cpu_clk_en !== 1'b0 || {done_cause, cycle_count} !== exp_v) begin
      bad++;
      $display("FAIL step_stop: done=%b en=%b cause=%0d cnt=%0d, want done=1 en=0 cause=3 cnt=3",
               done, cpu_clk_en, done_cause, cycle_count);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, en;
    bit to;
    bit hit;
    start_run(MODE_FREE, 32'd0);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cycle_count == 32'd5) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL midrun_reach5: cnt=%0d, want 5", cycle_count);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (cpu_rst !== 1'b1 || cpu_clk_en !== 1'b0 || cycle_count !== '0 || busy !== 1'b0 ||
        s_cpu_rst !== 1'b1 || s_cpu_clk_en !== 1'b0) begin
      bad++;
      $display("FAIL midrun_async_reset: rst=%b en=%b cnt=%0d busy=%b, want 1 0 0 0",
               cpu_rst, cpu_clk_en, cycle_count, busy);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (cpu_rst !== 1'b0 || cpu_clk_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cycle_count !== '0) begin
      bad++;
      $display("FAIL midrun_idle: rst=%b en=%b busy=%b done=%b cnt=%0d, want all 0",
               cpu_rst, cpu_clk_en, busy, done, cycle_count);
    end
    exp_q.push_back({CAUSE_HALT, 32'd3});
    start_run(MODE_FREE, 32'd0);
    run_until_done(100, 3, 0, cyc, en, to);
    exp_v = exp_q.pop_front();
    total++;
    if (to || en !== 3 || {done_cause, cycle_count} !== exp_v) begin
      bad++;
      $display("FAIL midrun_restart: timeout=%b en_edges=%0d cause=%0d cnt=%0d, want en=3 cause=1 cnt=3",
               to, en, done_cause, cycle_count);
    end
  endtask

  task automatic test_saturation();
    int cyc, en;
    bit to;
    exp_q.push_back({CAUSE_STOP, 32'd20});
    exp_q.push_back({CAUSE_STOP, 32'd15});
    start_run(MODE_FREE, 32'd0);
    run_until_done(100, 0, 20, cyc, en, to);
    exp_v = exp_q.pop_front();
    total++;
    if (to || en !== 20 || {done_cause, cycle_count} !== exp_v) begin
      bad++;
      $display("FAIL stop20_wide: timeout=%b en_edges=%0d cause=%0d cnt=%0d, want en=20 cause=3 cnt=20",
               to, en, done_cause, cycle_count);
    end
    exp_v = exp_q.pop_front();
    total++;
    if (s_done !== 1'b1 || {s_done_cause, 28'd0, s_cycle_count} !== exp_v) begin
      bad++;
      $display("FAIL saturate_narrow: done=%b cause=%0d cnt=%0d, want done=1 cause=3 cnt=15",
               s_done, s_done_cause, s_cycle_count);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    mode      = 2'd0;
    run_limit = '0;
    step      = 1'b0;
    stop      = 1'b0;
    halt_req  = 1'b0;

    test_reset();
    test_bounded();
    test_halt();
    test_single_step();
    test_reset_mid_run();
    test_saturation();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Synthesizable run controller for the single-cycle CPU. It replaces fixed testbench reset and stop timing with a parametrised, cycle-exact sequencer. It stretches reset to the CPU and gates the CPU clock enable in three modes: free-run, bounded-run and single-step. It counts executed cycles and reports why execution stopped. It sits between the board or bench reset/clock and `top_cpu`, driving `top_cpu`'s active-high reset and clock enable.

## Interface
- `RST_CYCLES`, default 2: cycles `cpu_rst` is held after the synchronised reset release (must be ≥1).
- `CNT_W`, default 32: width of the cycle counter and `run_limit`.
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset; assertion is immediate, release is synchronised internally.
- `start` in 1: one-cycle pulse; launches a run from IDLE or DONE.
- `mode` in 2: 0 free-run, 1 bounded-run, 2 single-step, 3 reserved (treated as 0). Sampled on `start`.
- `run_limit` in CNT_W: maximum cycles in bounded mode. Sampled on `start`.
- `step` in 1: one-cycle pulse; in single-step mode, enables exactly one CPU cycle.
- `stop` in 1: software abort of a run.
- `halt_req` in 1: CPU halt indication (e.g. ebreak/halt opcode). Sampled only while `cpu_clk_en`=1.
- `cpu_rst` out 1: active-high reset to `top_cpu`.
- `cpu_clk_en` out 1: registered clock enable to `top_cpu`.
- `cycle_count` out CNT_W: number of enabled CPU cycles in the current or last run.
- `done` out 1: run finished; held until the next `start`.
- `done_cause` out 2: 0 none, 1 halt, 2 limit, 3 stop.
- `busy` out 1: high in RUN, STEP_WAIT and STEP_EXEC.

## Operation
- States:
  - RST_HOLD: `cpu_rst`=1.
  - IDLE.
  - RUN: `cpu_clk_en`=1.
  - STEP_WAIT.
  - STEP_EXEC: `cpu_clk_en`=1.
  - DONE: `done`=1.
- Reset values while `reset_n`=0:
  - state RST_HOLD, `cpu_rst`=1, all other outputs 0, hold counter 0.
- RST_HOLD → IDLE after RST_CYCLES edges with the synchronised reset released.
- Transitions on `start`, out of IDLE or DONE:
  - `start` latches `mode` and `run_limit`.
  - It clears `cycle_count`, `done` and `done_cause`.
  - mode 0/3 → RUN.
  - mode 2 → STEP_WAIT.
  - mode 1 → RUN if `run_limit`≠0, else DONE with cause 2 and count 0.
- Counting: `cycle_count` increments on every edge where `cpu_clk_en`=1 and saturates at all-ones (no wrap).
- Exits from RUN, in priority order:
  - `halt_req` → DONE, cause 1.
  - `stop` → DONE, cause 3.
  - Bounded mode with the post-increment count equal to `run_limit` → DONE, cause 2.
  - In each case the count includes the exiting cycle.
- Single-step:
  - STEP_WAIT + `step` → STEP_EXEC.
  - STEP_EXEC always lasts one cycle, then:
    - `halt_req` → DONE, cause 1.
    - `stop` → DONE, cause 3.
    - Otherwise → STEP_WAIT.
  - STEP_WAIT + `stop` → DONE, cause 3, even if `step` is asserted in the same cycle.
  - `step` outside STEP_WAIT is ignored.
- Ignored inputs:
  - `start` in RUN, STEP_WAIT or STEP_EXEC.
  - `step`, `stop`, `start` in RST_HOLD.
- `cpu_rst` is asserted only in RST_HOLD. A `start` does not reset the CPU; architectural state persists across runs.

## Timing
- `reset_n` falling edge: `cpu_rst`=1 and `cpu_clk_en`=0 immediately (asynchronous), including mid-run.
- `reset_n` release:
  - The synchroniser releases on the 2nd rising edge.
  - `cpu_rst` falls on rising edge 2+RST_CYCLES after `reset_n` rises.
- `start` sampled at edge N:
  - `cpu_clk_en`=1 from N to N+1 (first enabled CPU edge is N+1).
  - `busy` rises at N.
- Bounded run with limit L: exactly L enabled edges. `cpu_clk_en` falls and `done` rises at the same edge that makes the count equal L.
- `halt_req` sampled at edge M while enabled:
  - The cycle ending at M is counted.
  - `cpu_clk_en`=0 after M.
  - `done`=1 after M.
- `step` at edge S: exactly one enabled edge, S+1.
- All outputs are registered; no combinational input→output paths.

## Structure
- Package `cpu_ctrl_pkg`:
  - State encoding.
  - Mode codes (MODE_FREE, MODE_BOUNDED, MODE_STEP).
  - Cause codes (CAUSE_NONE, CAUSE_HALT, CAUSE_LIMIT, CAUSE_STOP).
- Sub-module `rst_sync`: 2-flop asynchronous-assert, synchronous-release reset synchroniser, instantiated once.
- The FSM, hold counter and cycle counter are in `cpu_run_ctrl`.

## Test plan
- Reset release, RST_CYCLES=2: `reset_n` low 3 cycles then high → `cpu_rst` falls exactly 4 edges after release; all other outputs 0 throughout.
- Bounded run, mode 1, `run_limit`=10, no halt → `cpu_clk_en` high for exactly 10 edges; `cycle_count`=10, `done`=1, `done_cause`=2. Also, `run_limit`=0 → `done` after 1 edge, count 0, cause 2.
- Free run, mode 0, `halt_req` at the 7th enabled edge → `cycle_count`=7, cause 1. With `run_limit`=7 in mode 1 and `halt_req` on edge 7 → cause 1 (halt wins).
- Single-step: 3 `step` pulses spaced 4 cycles apart → 3 isolated one-cycle enables, count 3. Then `stop` together with `step` in STEP_WAIT → DONE, cause 3, count 3.
- Reset mid-run: `reset_n` low at count 5 in free-run → `cpu_rst`=1 and `cpu_clk_en`=0 asynchronously; `cycle_count`=0; after re-release the state is IDLE and `start` restarts counting from 0.
- Saturation, CNT_W=4, free-run for 20 cycles then `stop` → `cycle_count` holds 15, cause 3.
